// File: rtl/slice_order_collector.sv
// Merges per-parser slice streams back into dispatch order using an order FIFO
// of parser indices; the FIFO head owns the registered downstream port.
module slice_order_collector #(
  parameter int NUM_PARSER = 6,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16,
  localparam int PW = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PARSER-1:0]        dispatch,
  output logic                         stop_out,
  input  logic [NUM_PARSER-1:0]        p_valid,
  input  logic [NUM_PARSER*DATA_W-1:0] p_data,
  input  logic [NUM_PARSER-1:0]        p_last,
  output logic [NUM_PARSER-1:0]        p_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  output logic [PW-1:0]                out_parser,
  input  logic                         out_ready,
  output logic [15:0]                  slice_done_cnt,
  output logic                         dispatch_err,
  output logic                         idle
);

  logic [PW-1:0]     r_fifo [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [PW-1:0]     r_out_parser;
  logic [15:0]       r_done_cnt;
  logic              r_err;

  logic [PW-1:0]         w_push_idx;
  logic                  w_found;
  logic                  w_multi;
  logic [PW-1:0]         w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_out_free;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_W-1:0]     w_sel_data;
  logic [NUM_PARSER-1:0] w_p_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;

  // Lowest set bit wins when the dispatch vector is not one-hot.
  always_comb begin
    w_push_idx = '0;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < NUM_PARSER; i++) begin
      if (dispatch[i] && !w_found) begin
        w_push_idx = PW'(i);
        w_found    = 1'b1;
      end
    end
  end

  assign w_multi    = |(dispatch & (dispatch - NUM_PARSER'(1)));
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_out_free = ~r_out_valid | out_ready;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_p_ready   = '0;
    for (int unsigned i = 0; i < NUM_PARSER; i++) begin
      if (w_head == PW'(i)) begin
        w_sel_valid  = p_valid[i];
        w_sel_last   = p_last[i];
        w_sel_data   = p_data[i*DATA_W +: DATA_W];
        w_p_ready[i] = ~w_empty & w_out_free;
      end
    end
  end

  assign w_accept = ~w_empty & w_out_free & w_sel_valid;
  assign w_pop    = w_accept & w_sel_last;
  assign w_push   = (|dispatch) & ~w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_parser <= '0;
      r_done_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_idx;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_done_cnt <= r_done_cnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if ((|dispatch) && (w_multi || w_full))
        r_err <= 1'b1;
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_sel_data;
        r_out_last   <= w_sel_last;
        r_out_parser <= w_head;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign stop_out       = (r_count >= (AW+1)'(DEPTH-2));
  assign p_ready        = w_p_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign out_parser     = r_out_parser;
  assign slice_done_cnt = r_done_cnt;
  assign dispatch_err   = r_err;
  assign idle           = w_empty & ~r_out_valid;

endmodule

// File: tb/tb_slice_order_collector.sv
// Randomized scoreboard bench for slice_order_collector: a queue-based model of
// dispatch order and per-parser beat streams predicts every downstream beat.
module tb_slice_order_collector;
  localparam int NP    = 6;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int PW    = 3;

  typedef struct packed {
    logic [PW-1:0] parser;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      dispatch;
  logic               stop_out;
  logic [NP-1:0]      p_valid;
  logic [NP*DW-1:0]   p_data;
  logic [NP-1:0]      p_last;
  logic [NP-1:0]      p_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic [PW-1:0]      out_parser;
  logic               out_ready;
  logic [15:0]        slice_done_cnt;
  logic               dispatch_err;
  logic               idle;

  slice_order_collector #(.NUM_PARSER(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .dispatch(dispatch), .stop_out(stop_out),
    .p_valid(p_valid), .p_data(p_data), .p_last(p_last), .p_ready(p_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_parser(out_parser), .out_ready(out_ready),
    .slice_done_cnt(slice_done_cnt), .dispatch_err(dispatch_err), .idle(idle)
  );

  always #5 clk = ~clk;

  // Reference model state
  beat_t beatq [NP][$];
  beat_t exp_q [$];
  int    order_q [$];
  int    mheld;
  int    mdone;
  bit    exp_err;
  bit    stop_d;
  int    n_pass = 0;
  int    n_total = 0;
  int    n_xfer = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [NP-1:0] onehot();
    logic [NP-1:0] v;
    v = '0;
    v[$urandom_range(NP-1)] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    order_q.delete();
    exp_q.delete();
    for (int i = 0; i < NP; i++) beatq[i].delete();
    mheld = 0; mdone = 0; exp_err = 1'b0; stop_d = 1'b0;
  endtask

  // One clock cycle: drive at negedge, capture handshakes, update model after posedge.
  task automatic step(input logic [NP-1:0] disp, input int len, input int vprob, input bit ordy);
    logic [NP-1:0] hs;
    bit xfer, full, stop_s;
    int idx, L;
    beat_t b;
    @(negedge clk);
    dispatch  = disp;
    out_ready = ordy;
    for (int i = 0; i < NP; i++) begin
      if (beatq[i].size() != 0 && $urandom_range(99) < vprob) begin
        p_valid[i] = 1'b1;
        p_data[i*DW +: DW] = beatq[i][0].data;
        p_last[i] = beatq[i][0].last;
      end else begin
        p_valid[i] = 1'b0;
        p_data[i*DW +: DW] = {$urandom, $urandom};
        p_last[i] = 1'($urandom_range(1));
      end
    end
    #1;
    hs     = p_valid & p_ready;
    xfer   = (mheld != 0) && ordy;
    stop_s = stop_out;
    @(posedge clk);
    full = (order_q.size() == DEPTH);
    if (disp != '0) begin
      idx = 0;
      for (int i = NP - 1; i >= 0; i--) if (disp[i]) idx = i;
      if ($countones(disp) > 1) exp_err = 1'b1;
      if (full) exp_err = 1'b1;
      else begin
        order_q.push_back(idx);
        L = (len == 0) ? $urandom_range(4, 1) : len;
        for (int j = 0; j < L; j++) begin
          b.parser = PW'(idx);
          b.data   = {$urandom, $urandom};
          b.last   = (j == L - 1);
          beatq[idx].push_back(b);
          exp_q.push_back(b);
        end
      end
    end
    if (xfer) mheld--;
    if (hs != '0) mheld++;
    for (int i = 0; i < NP; i++) begin
      if (hs[i] && beatq[i].size() != 0) begin
        b = beatq[i].pop_front();
        if (b.last && order_q.size() != 0) begin
          void'(order_q.pop_front());
          mdone++;
        end
      end
    end
    stop_d = stop_s;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 500 && (order_q.size() != 0 || mheld != 0)) begin
      step('0, 0, 100, 1'b1);
      k++;
    end
    if (order_q.size() != 0 || mheld != 0) fail_now("drain_timeout");
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_parser", out_parser, 0);
    chk("rst_done_cnt", slice_done_cnt, 0);
    chk("rst_err", dispatch_err, 0);
    chk("rst_p_ready", p_ready, 0);
    chk("rst_stop", stop_out, 0);
    chk("rst_idle", idle, 1);
  endtask

  // Monitor: continuous output checks and in-order beat scoreboard.
  initial begin
    bit prev_stall;
    beat_t prev_beat, e, act;
    logic [NP-1:0] epr;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        act = {out_parser, out_data, out_last};
        epr = '0;
        if (order_q.size() != 0 && (mheld == 0 || out_ready)) epr[order_q[0]] = 1'b1;
        chk("out_valid", out_valid, (mheld != 0));
        chk("p_ready", p_ready, epr);
        chk("stop_out", stop_out, (order_q.size() >= DEPTH - 2));
        chk("idle", idle, (order_q.size() == 0 && mheld == 0));
        chk("dispatch_err", dispatch_err, exp_err);
        chk("slice_done_cnt", slice_done_cnt, 16'(mdone));
        if (prev_stall) chk("held_beat", act, prev_beat);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_beat");
          else begin
            e = exp_q.pop_front();
            chk("beat", act, e);
          end
          n_xfer++;
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = act;
      end
    end
  end

  initial begin
    int x0;
    rst = 1'b1; dispatch = '0; p_valid = '0; p_data = '0; p_last = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_values();
    rst = 1'b0;

    // In-order merge: slices of 3, 2, 1 beats to parsers 0, 1, 2.
    x0 = n_xfer;
    step(6'b000001, 3, 100, 1'b1);
    step(6'b000010, 2, 100, 1'b1);
    step(6'b000100, 1, 100, 1'b1);
    repeat (5) step('0, 0, 100, 1'b1);
    #1;
    chk("merge_no_bubble", n_xfer - x0, 6);
    chk("merge_done", slice_done_cnt, 3);
    drain();

    // Back-pressure mid-slice.
    step(6'b001000, 4, 100, 1'b1);
    step('0, 0, 100, 1'b1);
    repeat (5) step('0, 0, 100, 1'b0);
    #1;
    chk("bp_valid_held", out_valid, 1);
    drain();

    // Fill with a distributor that honours its registered stop.
    for (int k = 0; k < 30; k++) step(stop_d ? '0 : onehot(), 1, 0, 1'b1);
    #1;
    chk("full_stop", stop_out, 1);
    chk("full_no_err", dispatch_err, 0);
    drain();

    // Multi-hot dispatch, then overflow.
    step(6'b000110, 1, 0, 1'b1);
    #1;
    chk("multi_err", dispatch_err, 1);
    for (int k = 0; k < 20; k++) step(onehot(), 1, 0, 1'b1);
    #1;
    chk("overflow_err", dispatch_err, 1);
    chk("overflow_stop", stop_out, 1);
    repeat (3) step('0, 0, 100, 1'b1);

    // Reset mid-slice discards everything.
    @(negedge clk);
    rst = 1'b1; dispatch = '0; p_valid = '0; out_ready = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk); #1;
    check_reset_values();
    rst = 1'b0;

    // Wrap with back-to-back one-beat slices: push coincides with pop.
    for (int k = 0; k < 40; k++) step(NP'(1) << (k % NP), 1, 100, 1'b1);
    drain();
    #1;
    chk("wrap_done", slice_done_cnt, 40);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      step((!stop_d && $urandom_range(99) < 40) ? onehot() : '0, 0, 70,
           ($urandom_range(99) < 75));
    drain();
    #1;
    chk("final_done", slice_done_cnt, 16'(mdone));
    chk("final_idle", idle, 1);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/slice_order_collector.md
# slice_order_collector

Merges the output streams of the NUM_PARSER second-level parsers back into one stream in the exact order in which the distributor handed slices out. Records the one-hot dispatch grant of every slice in an order FIFO, then grants the shared downstream port to one parser at a time, from the slice's first beat to its `last` beat. Sits between the parser array and the downstream writer. Back-pressures the distributor through its `stop` input when the order FIFO nears full.

## Interface
- NUM_PARSER, 6, number of parsers; width of all one-hot vectors
- DATA_W, 64, width of one parser output beat
- DEPTH, 16, order FIFO entries; power of two, ≥4
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- dispatch  in  NUM_PARSER  one-hot; a nonzero cycle records one dispatched slice to parser index = set bit
- stop_out  out  1  to distributor `stop`
- p_valid  in  NUM_PARSER  per-parser beat valid
- p_data  in  NUM_PARSER*DATA_W  parser i beat at [i*DATA_W +: DATA_W]
- p_last  in  NUM_PARSER  beat is the final beat of that parser's current slice
- p_ready  out  NUM_PARSER  per-parser accept
- out_valid  out  1  registered output beat valid
- out_data  out  DATA_W  registered beat
- out_last  out  1  registered last flag
- out_parser  out  clog2(NUM_PARSER)  source parser index of the beat
- out_ready  in  1  downstream accept
- slice_done_cnt  out  16  completed slices, wraps 0xFFFF→0
- dispatch_err  out  1  sticky: multi-hot dispatch or push while full
- idle  out  1  order FIFO empty and no output beat held

## Operation
- Order FIFO: DEPTH×clog2(NUM_PARSER), pointers wr_ptr/rd_ptr (clog2(DEPTH) bits, wrap naturally), occupancy count (clog2(DEPTH)+1 bits).
- Push: dispatch≠0 → encode lowest set bit to index, write at wr_ptr.
- Multi-hot dispatch → push lowest index, set dispatch_err.
- Push when count==DEPTH → drop, set dispatch_err.
- dispatch_err clears only on rst.
- head = FIFO[rd_ptr], valid when count≠0.
- stop_out = (count ≥ DEPTH−2), combinational from registered count. This covers the distributor's one-cycle registered stop, so at most one further dispatch arrives after assertion; max occupancy is DEPTH−1 in legal operation.
- Grant: out_free = ~out_valid | out_ready.
- p_ready[i] = (count≠0) & (head==i) & out_free; all other bits 0.
- Accept: p_valid[head] & p_ready[head]. Loads out_data/out_last/out_parser from parser head and sets out_valid.
- If out_ready & out_valid & no accept → out_valid clears.
- Accept with p_last[head]=1 → pop (rd_ptr+1, count−1) and slice_done_cnt+1.
- Simultaneous push and pop → count unchanged, both pointers advance.
- Beats of non-head parsers are held off (p_ready=0) indefinitely; no reordering buffer.
- Pushing to the parser currently at head is legal; the entries are served in sequence.
- idle = (count==0) & ~out_valid.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_parser 0, slice_done_cnt 0, dispatch_err 0, count 0, pointers 0; hence p_ready 0, stop_out 0, idle 1.
- rst mid-slice discards FIFO contents and the held beat; the next cycle behaves as post-reset.
- Dispatch at cycle t: head visible and p_ready assertable at t+1 (if FIFO was empty).
- Parser accept at t → out_valid at t+1.
- Throughput 1 beat/cycle with out_ready held 1, including across slice boundaries. The pop at last-accept t makes the next head's p_ready valid at t+1.
- stop_out reflects count at start of cycle; the same-cycle push is not included.

## Test plan
- Reset: hold rst 2 cycles → all outputs at reset values; idle=1, stop_out=0.
- In-order merge, NUM_PARSER=6: dispatch 0,1,2. Parser 2 presents 1 beat (last) first, parser 1 presents 2 beats, parser 0 presents 3 beats, out_ready=1 → out_parser sequence 0,0,0,1,1,2 with out_last on 3rd, 5th, 6th beats; slice_done_cnt=3; no bubbles.
- Back-pressure: out_ready=0 for 5 cycles mid-slice → out_data stable, p_ready=0 throughout. No beat is lost or duplicated when out_ready returns.
- Full: DEPTH=16, dispatch every cycle, no parser output → stop_out rises when count=14. With the distributor model honoring registered stop, count peaks at 15; dispatch_err stays 0.
- Errors: dispatch=6'b000110 → index 1 recorded, dispatch_err=1. Pushes at count=16 are dropped, dispatch_err stays 1, count stays 16.
- Wrap and simultaneous push/pop: 40 one-beat slices round-robin with dispatch coinciding with last-accept → order preserved across pointer wrap, count constant during overlap, slice_done_cnt=40.
